// File: rtl/seq_alu_core_if.sv
// Command/result bundle between an operand source and the sequential ALU.
// Latency: none, wires only.
// Backpressure: the source may assert start only while busy is low. A start seen while busy is high is dropped.
// Ports:
//    start/inputA/inputB/command : source -> ALU request
//    busy/done/result/error      : ALU -> source/consumer status
interface seq_alu_core_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic [WIDTH-1:0]     inputA;
   logic [WIDTH-1:0]     inputB;
   logic [3:0]           command;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic [1:0]           error;

   modport master (
      output start, inputA, inputB, command,
      input  busy, done, result, error
   );

   modport slave (
      input  start, inputA, inputB, command,
      output busy, done, result, error
   );
endinterface

// File: rtl/seq_alu_core.sv
// Sequential unsigned ALU: ADD, SUB, MUL (shift-add) and DIV/MOD (restoring division).
// Latency: 1 cycle for ADD, SUB, illegal commands and divide-by-zero. WIDTH cycles for MUL and for DIV/MOD with a non-zero divisor.
// Backpressure: busy is high while an operation runs. A start seen while busy is high is dropped, not queued.
// Ports:
//    clk, rst_n : clock and asynchronous active-low reset
//    bus        : slave side of seq_alu_core_if (start/operands/command in; busy/done/result/error out)
module seq_alu_core #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_alu_core_if.slave      bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [3:0] CMD_ADD = 4'd0;
   localparam logic [3:0] CMD_SUB = 4'd1;
   localparam logic [3:0] CMD_MUL = 4'd2;
   localparam logic [3:0] CMD_DIV = 4'd3;
   localparam logic [3:0] CMD_MOD = 4'd4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   // a_q: MUL multiplicand, shifted left one place per step. DIV/MOD dividend, which becomes the quotient.
   logic [2*WIDTH-1:0]   a_q, a_d;
   // b_q: MUL multiplier, shifted right one place per step. DIV/MOD divisor, held constant.
   logic [WIDTH-1:0]     b_q, b_d;
   // acc_q: MUL partial product. For DIV/MOD, the partial remainder in its low bits.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic [1:0]           error_q, error_d;
   logic                 done_q, done_d;

   // Datapath for one step, computed from the registered operands only.
   logic [WIDTH:0]       sum, diff, rem_sh, rem_new;
   logic                 rem_ge, b_zero, accept, start_long;
   logic [WIDTH-1:0]     quo_new;
   logic [2*WIDTH-1:0]   acc_step;

   assign sum      = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q};
   assign diff     = {1'b0, a_q[WIDTH-1:0]} - {1'b0, b_q};   // diff[WIDTH] is the borrow
   assign acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
   assign rem_sh   = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
   assign rem_ge   = (rem_sh >= {1'b0, b_q});
   assign rem_new  = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
   assign quo_new  = {a_q[WIDTH-2:0], rem_ge};
   assign b_zero   = (b_q == '0);

   assign accept     = (state_q == IDLE) && bus.start;
   // Iterative operations run WIDTH steps. All others finish on the first RUN edge.
   assign start_long = (bus.command == CMD_MUL) ||
                       (((bus.command == CMD_DIV) || (bus.command == CMD_MOD)) && (bus.inputB != '0));

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      error_d  = error_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               op_d    = bus.command;
               a_d     = {{WIDTH{1'b0}}, bus.inputA};
               b_d     = bus.inputB;
               acc_d   = '0;
               // Short operations start the counter at its terminal value.
               cnt_d   = start_long ? '0 : LAST;
            end
         end
         RUN: begin
            if (op_q == CMD_MUL) begin
               acc_d = acc_step;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else if (((op_q == CMD_DIV) || (op_q == CMD_MOD)) && !b_zero) begin
               acc_d = {{(WIDTH-1){1'b0}}, rem_new};
               a_d   = {{WIDTH{1'b0}}, quo_new};
            end

            if (cnt_q == LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               case (op_q)
                  CMD_ADD: begin
                     result_d = {{(WIDTH-1){1'b0}}, sum};
                     error_d  = {1'b0, sum[WIDTH]};
                  end
                  CMD_SUB: begin
                     result_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                     error_d  = {1'b0, diff[WIDTH]};
                  end
                  CMD_MUL: begin
                     result_d = acc_step;
                     error_d  = 2'b00;
                  end
                  CMD_DIV, CMD_MOD: begin
                     if (b_zero) begin
                        result_d = '0;
                        error_d  = 2'b10;
                     end else begin
                        result_d = (op_q == CMD_DIV) ? {{WIDTH{1'b0}}, quo_new}
                                                     : {{WIDTH{1'b0}}, rem_new[WIDTH-1:0]};
                        error_d  = 2'b00;
                     end
                  end
                  default: begin
                     result_d = '0;
                     error_d  = 2'b11;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         error_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         error_q  <= error_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.error  = error_q;
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core at WIDTH=16, with hand-computed expected values.
// Latency: covers both the 1-cycle and the 16-cycle operations, plus back-to-back issue.
// Backpressure: checks that a start while busy is dropped, and checks an asynchronous reset in mid-operation.
module tb_seq_alu_core;
   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   logic [31:0] last_res;

   seq_alu_core_if #(.WIDTH(W)) bus ();

   seq_alu_core #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive a request in the low half of a cycle, wait for the accept edge,
   // then scramble the inputs so that any late sampling shows up.
   task automatic issue(input string tag, input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      chk({tag, ".idle"}, {63'd0, bus.busy}, 64'd0);
      bus.start   = 1'b1;
      bus.command = cmd;
      bus.inputA  = a;
      bus.inputB  = b;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.command = cmd ^ 4'h1;
      bus.inputA  = ~a;
      bus.inputB  = b ^ 16'h0005;
      chk({tag, ".busy"},  {63'd0, bus.busy}, 64'd1);
      chk({tag, ".dlow"},  {63'd0, bus.done}, 64'd0);
      chk({tag, ".hold"},  {32'd0, bus.result}, {32'd0, last_res});
   endtask

   // Count edges after the accept edge until done is seen. Optionally inject an
   // ADD request (expected to be ignored) just before edge number inject_at.
   task automatic wait_done(input int inject_at, output int lat, output int bcnt);
      lat  = 0;
      bcnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 100) begin
         if (inject_at != 0 && lat == inject_at - 1) begin
            bus.start   = 1'b1;
            bus.command = 4'd0;
            bus.inputA  = 16'd1;
            bus.inputB  = 16'd1;
         end
         @(posedge clk);
         #1;
         lat++;
         bus.start = 1'b0;
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic do_op(input string tag, input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input logic [1:0] exp_err);
      int lat, bcnt;
      issue(tag, cmd, a, b);
      wait_done(0, lat, bcnt);
      chk({tag, ".lat"},  lat, exp_lat);
      chk({tag, ".bcnt"}, bcnt, exp_lat);
      chk({tag, ".res"},  {32'd0, bus.result}, {32'd0, exp_res});
      chk({tag, ".err"},  {62'd0, bus.error}, {62'd0, exp_err});
      last_res = exp_res;
   endtask

   initial begin
      int lat, bcnt;
      n_tests     = 0;
      n_fail      = 0;
      last_res    = 32'd0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.command = 4'd0;
      bus.inputA  = 16'd0;
      bus.inputB  = 16'd0;
      #2;
      chk("rst.busy", {63'd0, bus.busy}, 64'd0);
      chk("rst.done", {63'd0, bus.done}, 64'd0);
      chk("rst.res",  {32'd0, bus.result}, 64'd0);
      chk("rst.err",  {62'd0, bus.error}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("add_a", 4'd0, 16'h7FFF, 16'h0003, 1,  32'h0000_8002, 2'b00);
      do_op("add_c", 4'd0, 16'hFFFF, 16'h0001, 1,  32'h0001_0000, 2'b01);
      do_op("sub_b", 4'd1, 16'h0003, 16'h0005, 1,  32'h0000_FFFE, 2'b01);
      do_op("sub_a", 4'd1, 16'h7FFF, 16'h0003, 1,  32'h0000_7FFC, 2'b00);
      do_op("mul_m", 4'd2, 16'hFFFF, 16'hFFFF, 16, 32'hFFFE_0001, 2'b00);
      do_op("mul_s", 4'd2, 16'h7FFF, 16'h0003, 16, 32'h0001_7FFD, 2'b00);
      // Back-to-back: the second request is driven during the first one's done cycle.
      do_op("div",   4'd3, 16'd100,  16'd7,    16, 32'd14,        2'b00);
      do_op("mod",   4'd4, 16'd100,  16'd7,    16, 32'd2,         2'b00);
      do_op("div0",  4'd3, 16'd5,    16'd0,    1,  32'd0,         2'b10);
      do_op("mod0",  4'd4, 16'd5,    16'd0,    1,  32'd0,         2'b10);
      do_op("ill7",  4'd7, 16'h1234, 16'h0001, 1,  32'd0,         2'b11);
      do_op("ill15", 4'd15, 16'h00FF, 16'h00FF, 1, 32'd0,         2'b11);

      // A start while busy is dropped. The multiply must finish unaffected.
      issue("ign", 4'd2, 16'h1234, 16'h0010);
      wait_done(5, lat, bcnt);
      chk("ign.lat", lat, 16);
      chk("ign.res", {32'd0, bus.result}, 64'h0000_0000_0001_2340);
      chk("ign.err", {62'd0, bus.error}, 64'd0);
      last_res = 32'h0001_2340;
      @(posedge clk);
      #1;
      chk("ign.dpulse", {63'd0, bus.done}, 64'd0);
      chk("ign.nobusy", {63'd0, bus.busy}, 64'd0);

      // Asynchronous reset in the middle of a multiply.
      issue("rmul", 4'd2, 16'hFFFF, 16'h00FF);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst.busy", {63'd0, bus.busy}, 64'd0);
      chk("arst.done", {63'd0, bus.done}, 64'd0);
      chk("arst.res",  {32'd0, bus.result}, 64'd0);
      chk("arst.err",  {62'd0, bus.error}, 64'd0);
      last_res = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op("add11", 4'd0, 16'd1, 16'd1, 1, 32'd2, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
